// File: rtl/peak_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : peak_search_ctrl
//  Description : Per-frame spectral peak search over a bin window
//                [k_lo, k_hi]. It applies a detection threshold and presents
//                the winning bin through a valid/ready result register.
//                It raises a sticky overrun flag when an unconsumed result
//                is overwritten.
//  Options     : PEAK_NEIGHBORS_EN adds result_mag_lo / result_mag_hi, the
//                magnitudes of the bins adjacent to the peak.
//  Revision    : 1.0  initial release
// ============================================================================
module peak_search_ctrl #(
  parameter int MAG_WIDTH = 96,
  parameter int K_WIDTH   = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 data_valid,
  input  logic [MAG_WIDTH-1:0] data_in,
  input  logic [K_WIDTH-1:0]   k_in,
  input  logic [K_WIDTH-1:0]   cfg_k_lo,
  input  logic [K_WIDTH-1:0]   cfg_k_hi,
  input  logic [MAG_WIDTH-1:0] cfg_threshold,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [K_WIDTH-1:0]   result_k,
  output logic [MAG_WIDTH-1:0] result_mag,
  output logic                 result_found,
  output logic                 overrun
`ifdef PEAK_NEIGHBORS_EN
  ,
  output logic [MAG_WIDTH-1:0] result_mag_lo,
  output logic [MAG_WIDTH-1:0] result_mag_hi
`endif
);

  localparam logic [K_WIDTH-1:0] MAX_K = '1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Frame configuration, frozen for the duration of a search
  logic [K_WIDTH-1:0]   sh_lo, sh_hi;
  logic [MAG_WIDTH-1:0] sh_thr;

  // Running maximum tracker
  logic [MAG_WIDTH-1:0] run_max, max_nxt;
  logic [K_WIDTH-1:0]   run_k, k_nxt;
  logic                 hit, hit_nxt;

  logic searching, in_win, frame_end, new_peak, found_nxt;

  assign searching = (state == SEARCH);
  assign busy      = searching;
  assign in_win    = searching && data_valid && (k_in >= sh_lo) && (k_in <= sh_hi);
  assign frame_end = searching && data_valid && (k_in == MAX_K);
  // Strict compare: the earliest bin wins ties
  assign new_peak  = in_win && (data_in > run_max);

  // Tracker next values; the frame's final sample is folded in before commit
  always_comb begin
    max_nxt   = run_max;
    k_nxt     = run_k;
    hit_nxt   = hit;
    if (new_peak) begin
      max_nxt = data_in;
      k_nxt   = k_in;
      hit_nxt = 1'b1;
    end
    found_nxt = hit_nxt && (max_nxt >= sh_thr);
  end

`ifdef PEAK_NEIGHBORS_EN
  localparam logic [K_WIDTH-1:0] K_ONE = 1;

  logic [MAG_WIDTH-1:0] run_lo, run_hi, lo_nxt, hi_nxt;
  logic                 hi_pend, pend_nxt;
  logic [MAG_WIDTH-1:0] prev_mag;
  logic [K_WIDTH-1:0]   prev_k;
  logic                 prev_ok;

  // Neighbour capture: a new peak takes the previous in-window sample as its
  // left neighbour and waits for the next in-window sample as its right one
  always_comb begin
    lo_nxt   = run_lo;
    hi_nxt   = run_hi;
    pend_nxt = hi_pend;
    if (new_peak) begin
      lo_nxt   = (prev_ok && (prev_k == k_in - K_ONE)) ? prev_mag : '0;
      hi_nxt   = '0;
      pend_nxt = 1'b1;
    end else if (in_win && hi_pend) begin
      hi_nxt   = (k_in == run_k + K_ONE) ? data_in : '0;
      pend_nxt = 1'b0;
    end
  end

  // Neighbour tracking registers, cleared whenever a search is armed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_lo   <= '0;
      run_hi   <= '0;
      hi_pend  <= 1'b0;
      prev_mag <= '0;
      prev_k   <= '0;
      prev_ok  <= 1'b0;
    end else if (start) begin
      run_lo   <= '0;
      run_hi   <= '0;
      hi_pend  <= 1'b0;
      prev_mag <= '0;
      prev_k   <= '0;
      prev_ok  <= 1'b0;
    end else if (searching) begin
      run_lo  <= lo_nxt;
      run_hi  <= hi_nxt;
      hi_pend <= pend_nxt;
      if (in_win) begin
        prev_mag <= data_in;
        prev_k   <= k_in;
        prev_ok  <= 1'b1;
      end
    end
  end

  // Neighbour result registers share the result handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_mag_lo <= '0;
      result_mag_hi <= '0;
    end else if (frame_end) begin
      result_mag_lo <= lo_nxt;
      result_mag_hi <= hi_nxt;
    end
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: start always (re)enters SEARCH, frame end returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (frame_end && !start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config shadow and running max; start re-arms even mid-frame (abort)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_lo   <= '0;
      sh_hi   <= '0;
      sh_thr  <= '0;
      run_max <= '0;
      run_k   <= '0;
      hit     <= 1'b0;
    end else if (start) begin
      sh_lo   <= cfg_k_lo;
      sh_hi   <= cfg_k_hi;
      sh_thr  <= cfg_threshold;
      run_max <= '0;
      run_k   <= cfg_k_lo;
      hit     <= 1'b0;
    end else if (searching) begin
      run_max <= max_nxt;
      run_k   <= k_nxt;
      hit     <= hit_nxt;
    end
  end

  // Result register: a commit beats a same-edge transfer; overwriting an
  // unconsumed result latches overrun until reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_valid <= 1'b0;
      result_k     <= '0;
      result_mag   <= '0;
      result_found <= 1'b0;
      overrun      <= 1'b0;
    end else if (frame_end) begin
      result_valid <= 1'b1;
      result_k     <= k_nxt;
      result_mag   <= max_nxt;
      result_found <= found_nxt;
      if (result_valid && !result_ready) overrun <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peak_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peak_search_ctrl
//  Description : Directed, table-driven bench for peak_search_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_peak_search_ctrl;

  localparam int MW = 96;
  localparam int KW = 12;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          data_valid = 1'b0;
  logic [MW-1:0] data_in = '0;
  logic [KW-1:0] k_in = '0;
  logic [KW-1:0] cfg_k_lo = '0;
  logic [KW-1:0] cfg_k_hi = '0;
  logic [MW-1:0] cfg_threshold = '0;
  logic          result_ready = 1'b0;
  logic          busy, result_valid, result_found, overrun;
  logic [KW-1:0] result_k;
  logic [MW-1:0] result_mag;
`ifdef PEAK_NEIGHBORS_EN
  logic [MW-1:0] result_mag_lo, result_mag_hi;
`endif

  peak_search_ctrl #(.MAG_WIDTH(MW), .K_WIDTH(KW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .data_valid(data_valid), .data_in(data_in), .k_in(k_in),
    .cfg_k_lo(cfg_k_lo), .cfg_k_hi(cfg_k_hi), .cfg_threshold(cfg_threshold),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_k(result_k), .result_mag(result_mag), .result_found(result_found),
    .overrun(overrun)
`ifdef PEAK_NEIGHBORS_EN
    , .result_mag_lo(result_mag_lo), .result_mag_hi(result_mag_hi)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  localparam logic [MW-1:0] BIG  = {1'b1, 94'b0, 1'b1};
  localparam logic [MW-1:0] BIG2 = {1'b0, {95{1'b1}}};
  localparam logic [MW-1:0] TOP  = {1'b1, 95'b0};

  typedef struct {
    logic [KW-1:0] lo, hi;
    logic [MW-1:0] thr;
    int            pat;
    logic [KW-1:0] ek;
    logic [MW-1:0] emag;
    logic          ef;
    logic [MW-1:0] enlo, enhi;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pattern 0: mag=k, bin 15 = 500. 1: bins 12,18 = 50. 2: all 1, bin 5 = 900.
  // 3: mag=k, bin 25 = BIG, bin 26 = BIG2 (differs only above bit 63 ordering).
  function automatic logic [MW-1:0] mag_of(input int pat, input int k);
    case (pat)
      0: return (k == 15) ? MW'(500) : MW'(k);
      1: return (k == 12 || k == 18) ? MW'(50) : '0;
      2: return (k == 5) ? MW'(900) : MW'(1);
      default: return (k == 25) ? BIG : ((k == 26) ? BIG2 : MW'(k));
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input logic [MW-1:0] thr);
    cfg_k_lo = lo; cfg_k_hi = hi; cfg_threshold = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Dense bins first..last, then optionally the frame-end bin 4095
  task automatic stream(input int pat, input int first, input int last, input bit with_end, input bit start_at_end);
    for (int k = first; k <= last; k++) begin
      data_valid = 1'b1; k_in = KW'(k); data_in = mag_of(pat, k);
      tick();
    end
    if (with_end) begin
      data_valid = 1'b1; k_in = '1; data_in = mag_of(pat, 4095);
      start = start_at_end;
      tick();
      start = 1'b0;
    end
    data_valid = 1'b0;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("valid_after_consume", MW'(result_valid), 0);
  endtask

  initial begin
    vecs[0] = '{10, 20, 100, 0, 15, 500, 1, 14, 16};
    vecs[1] = '{10, 20, 60, 1, 12, 50, 0, 0, 0};
    vecs[2] = '{10, 20, 50, 1, 12, 50, 1, 0, 0};
    vecs[3] = '{10, 20, 0, 2, 10, 1, 1, 0, 1};
    vecs[4] = '{30, 20, 0, 2, 30, 0, 0, 0, 0};
    vecs[5] = '{20, 30, TOP, 3, 25, BIG, 1, 24, BIG2};
    vecs[6] = '{15, 15, 500, 0, 15, 500, 1, 0, 0};
    vecs[7] = '{10, 20, 501, 0, 15, 500, 0, 14, 16};
    vecs[8] = '{4000, 4095, 0, 0, 4095, 4095, 1, 0, 0};

    // Reset state
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", MW'(busy), 0);
    check("rst_valid", MW'(result_valid), 0);
    check("rst_k", MW'(result_k), 0);
    check("rst_mag", result_mag, 0);
    check("rst_overrun", MW'(overrun), 0);

    // IDLE ignores a frame-end sample
    data_valid = 1'b1; k_in = '1; data_in = 7;
    tick();
    data_valid = 1'b0;
    check("idle_ignore_valid", MW'(result_valid), 0);

    // Full frame 0..4095
    arm(10, 20, 100);
    check("busy_after_start", MW'(busy), 1);
    stream(0, 0, 4094, 1'b1, 1'b0);
    check("full_valid", MW'(result_valid), 1);
    check("full_k", MW'(result_k), 15);
    check("full_mag", result_mag, 500);
    check("full_found", MW'(result_found), 1);
    check("full_busy", MW'(busy), 0);
`ifdef PEAK_NEIGHBORS_EN
    check("full_nlo", result_mag_lo, 14);
    check("full_nhi", result_mag_hi, 16);
`endif
    consume();

    // Table of sparse frames (bins 0..40 then 4095)
    for (int i = 0; i < 9; i++) begin
      arm(vecs[i].lo, vecs[i].hi, vecs[i].thr);
      stream(vecs[i].pat, 0, 40, 1'b1, 1'b0);
      check($sformatf("v%0d_valid", i), MW'(result_valid), 1);
      check($sformatf("v%0d_k", i), MW'(result_k), MW'(vecs[i].ek));
      check($sformatf("v%0d_mag", i), result_mag, vecs[i].emag);
      check($sformatf("v%0d_found", i), MW'(result_found), MW'(vecs[i].ef));
`ifdef PEAK_NEIGHBORS_EN
      check($sformatf("v%0d_nlo", i), result_mag_lo, vecs[i].enlo);
      check($sformatf("v%0d_nhi", i), result_mag_hi, vecs[i].enhi);
`endif
      // Held while not ready
      tick();
      check($sformatf("v%0d_hold", i), MW'(result_valid), 1);
      consume();
    end

    // Abort mid-frame at k=200, then cfg_k_hi changed during SEARCH
    arm(10, 20, 100);
    stream(0, 0, 199, 1'b0, 1'b0);
    cfg_k_lo = 30; cfg_k_hi = 35; cfg_threshold = 0;
    data_valid = 1'b1; k_in = 200; data_in = 200; start = 1'b1;
    tick();
    start = 1'b0; data_valid = 1'b0;
    check("abort_busy", MW'(busy), 1);
    check("abort_no_result", MW'(result_valid), 0);
    cfg_k_hi = 40;
    stream(0, 0, 40, 1'b1, 1'b0);
    check("shadow_k", MW'(result_k), 35);
    check("shadow_mag", result_mag, 35);
    check("shadow_found", MW'(result_found), 1);
`ifdef PEAK_NEIGHBORS_EN
    check("shadow_nlo", result_mag_lo, 34);
    check("shadow_nhi", result_mag_hi, 0);
`endif
    consume();

    // Start on the frame-end cycle: commit and re-arm together
    arm(10, 20, 0);
    cfg_k_lo = 10; cfg_k_hi = 20; cfg_threshold = 600;
    stream(1, 0, 40, 1'b1, 1'b1);
    check("restart_valid", MW'(result_valid), 1);
    check("restart_k", MW'(result_k), 12);
    check("restart_busy", MW'(busy), 1);
    consume();
    stream(0, 0, 40, 1'b1, 1'b0);
    check("relatch_k", MW'(result_k), 15);
    check("relatch_found", MW'(result_found), 0);
    check("relatch_overrun", MW'(overrun), 0);
    consume();

    // Backpressure and overrun
    arm(10, 20, 100);
    stream(0, 0, 40, 1'b1, 1'b0);
    check("ovr_first_k", MW'(result_k), 15);
    check("ovr_clear_before", MW'(overrun), 0);
    arm(10, 20, 50);
    stream(1, 0, 40, 1'b1, 1'b0);
    check("ovr_second_k", MW'(result_k), 12);
    check("ovr_second_mag", result_mag, 50);
    check("ovr_set", MW'(overrun), 1);
    tick(); tick(); tick();
    check("ovr_sticky", MW'(overrun), 1);
    check("ovr_hold_k", MW'(result_k), 12);
    consume();
    check("ovr_after_consume", MW'(overrun), 1);

    // Asynchronous reset mid-SEARCH, no clock edge involved
    arm(10, 20, 100);
    stream(0, 0, 20, 1'b0, 1'b0);
    check("pre_rst_busy", MW'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", MW'(busy), 0);
    check("arst_overrun", MW'(overrun), 0);
    check("arst_k", MW'(result_k), 0);
    check("arst_mag", result_mag, 0);
    check("arst_found", MW'(result_found), 0);
    #1;
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", MW'(busy), 0);
    check("post_rst_valid", MW'(result_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
